// File: rtl/serial_frame_receiver_if.sv
// Bundle of the serial line input and the decoded frame outputs of serial_frame_receiver.
// The master side drives the line; the slave side is the receiver.
interface serial_frame_receiver_if;
  logic       serial_in;
  logic       serial_out;
  logic       data_valid;
  logic [7:0] length;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] data_byte;
  logic       byte_valid;

  modport master (
    output serial_in,
    input  serial_out, data_valid, length, start, busy, done, data_byte, byte_valid
  );

  modport slave (
    input  serial_in,
    output serial_out, data_valid, length, start, busy, done, data_byte, byte_valid
  );
endinterface

// File: rtl/serial_frame_receiver.sv
// Receives frames of the form: start bit 0, 8-bit length (MSB first), then `length` payload bits.
// Payload bits are echoed with one cycle of latency and packed MSB-first into bytes.
module serial_frame_receiver (
  input  logic                   clk,
  input  logic                   rst,
  serial_frame_receiver_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, HEADER = 2'd1, PAYLOAD = 2'd2} state_t;

  state_t     state_p1, state_p0;
  logic [2:0] hdr_cnt_p1;
  logic [7:0] hdr_sh_p1;
  logic [7:0] rem_cnt_p1;
  logic [7:0] pay_cnt_p1;
  logic [2:0] byte_cnt_p1;
  logic [7:0] byte_sh_p1;

  logic [7:0] hdr_val;
  logic [7:0] byte_asm;
  logic       hdr_last;

  logic       serial_out_p0, data_valid_p0, start_p0, busy_p0, done_p0, byte_valid_p0;
  logic [7:0] length_p0, data_byte_p0;
  logic       serial_out_p1, data_valid_p1, start_p1, busy_p1, done_p1, byte_valid_p1;
  logic [7:0] length_p1, data_byte_p1;

  function automatic logic [7:0] shift_in(input logic [7:0] sh, input logic b);
    return (sh << 1) | {7'd0, b};
  endfunction

  // A partial final byte holds last_idx+1 bits in its LSBs; move them to the MSBs.
  function automatic logic [7:0] left_align(input logic [7:0] v, input logic [2:0] last_idx);
    return v << (3'd7 - last_idx);
  endfunction

  assign hdr_val  = shift_in(hdr_sh_p1, bus.serial_in);
  assign byte_asm = shift_in(byte_sh_p1, bus.serial_in);
  assign hdr_last = (hdr_cnt_p1 == 3'd7);

  always_ff @(posedge clk) begin
    if (!rst) state_p1 <= IDLE;
    else      state_p1 <= state_p0;
  end

  always_comb begin
    state_p0 = state_p1;
    case (state_p1)
      IDLE:    if (!bus.serial_in) state_p0 = HEADER;
      HEADER:  if (hdr_last) state_p0 = (hdr_val != 8'd0) ? PAYLOAD : IDLE;
      PAYLOAD: if (rem_cnt_p1 <= 8'd1) state_p0 = IDLE;
      default: state_p0 = IDLE;
    endcase
  end

  always_comb begin
    serial_out_p0 = 1'b1;
    data_valid_p0 = 1'b0;
    start_p0      = 1'b0;
    done_p0       = 1'b0;
    byte_valid_p0 = 1'b0;
    length_p0     = length_p1;
    data_byte_p0  = data_byte_p1;
    busy_p0       = (state_p0 != IDLE);
    case (state_p1)
      HEADER: begin
        if (hdr_last) begin
          length_p0 = hdr_val;
          start_p0  = 1'b1;
          done_p0   = (hdr_val == 8'd0);
        end
      end
      PAYLOAD: begin
        serial_out_p0 = bus.serial_in;
        data_valid_p0 = 1'b1;
        done_p0       = (rem_cnt_p1 == 8'd1);
        if (byte_cnt_p1 == 3'd7) begin
          data_byte_p0  = byte_asm;
          byte_valid_p0 = 1'b1;
        end else if (rem_cnt_p1 == 8'd1) begin
          data_byte_p0  = left_align(byte_asm, byte_cnt_p1);
          byte_valid_p0 = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath: header/payload shift registers and counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      hdr_cnt_p1  <= 3'd0;
      hdr_sh_p1   <= 8'd0;
      rem_cnt_p1  <= 8'd0;
      pay_cnt_p1  <= 8'd0;
      byte_cnt_p1 <= 3'd0;
      byte_sh_p1  <= 8'd0;
    end else begin
      case (state_p1)
        IDLE: begin
          if (!bus.serial_in) hdr_cnt_p1 <= 3'd0;
        end
        HEADER: begin
          hdr_sh_p1  <= hdr_val;
          hdr_cnt_p1 <= hdr_cnt_p1 + 3'd1;
          if (hdr_last) begin
            rem_cnt_p1  <= hdr_val;
            pay_cnt_p1  <= 8'd0;
            byte_cnt_p1 <= 3'd0;
            byte_sh_p1  <= 8'd0;
          end
        end
        PAYLOAD: begin
          byte_sh_p1  <= byte_asm;
          byte_cnt_p1 <= byte_cnt_p1 + 3'd1;
          pay_cnt_p1  <= pay_cnt_p1 + 8'd1;
          if (rem_cnt_p1 != 8'd0) rem_cnt_p1 <= rem_cnt_p1 - 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      serial_out_p1 <= 1'b1;
      data_valid_p1 <= 1'b0;
      length_p1     <= 8'h00;
      start_p1      <= 1'b0;
      busy_p1       <= 1'b0;
      done_p1       <= 1'b0;
      data_byte_p1  <= 8'h00;
      byte_valid_p1 <= 1'b0;
    end else begin
      serial_out_p1 <= serial_out_p0;
      data_valid_p1 <= data_valid_p0;
      length_p1     <= length_p0;
      start_p1      <= start_p0;
      busy_p1       <= busy_p0;
      done_p1       <= done_p0;
      data_byte_p1  <= data_byte_p0;
      byte_valid_p1 <= byte_valid_p0;
    end
  end

  assign bus.serial_out = serial_out_p1;
  assign bus.data_valid = data_valid_p1;
  assign bus.length     = length_p1;
  assign bus.start      = start_p1;
  assign bus.busy       = busy_p1;
  assign bus.done       = done_p1;
  assign bus.data_byte  = data_byte_p1;
  assign bus.byte_valid = byte_valid_p1;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Bench for serial_frame_receiver: expected per-cycle output records are generated from
// the frame contents as each line bit is driven, queued, and compared after the edge.
module tb_serial_frame_receiver;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_frame_receiver_if bus ();

  serial_frame_receiver dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef logic [21:0] rec_t;  // {serial_out, data_valid, length, start, busy, done, data_byte, byte_valid}

  rec_t       exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         dv_cnt  = 0;
  int         bv_cnt  = 0;
  string      tag     = "init";
  logic [7:0] last_len  = 8'h00;
  logic [7:0] last_byte = 8'h00;

  task automatic check_val(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic rec_t mk(input logic so, input logic dv, input logic [7:0] len,
                              input logic st, input logic bz, input logic dn,
                              input logic [7:0] db, input logic bv);
    return {so, dv, len, st, bz, dn, db, bv};
  endfunction

  function automatic rec_t observed();
    return {bus.serial_out, bus.data_valid, bus.length, bus.start, bus.busy,
            bus.done, bus.data_byte, bus.byte_valid};
  endfunction

  // Drive one line bit (and reset level) for the next edge; compare after the edge.
  task automatic step(input logic si, input logic r, input rec_t e);
    rec_t x;
    bus.serial_in = si;
    rst = r;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    check_val(tag, {10'd0, observed()}, {10'd0, x});
    if (bus.data_valid) dv_cnt++;
    if (bus.byte_valid) bv_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, mk(1'b1, 1'b0, last_len, 1'b0, 1'b0, 1'b0, last_byte, 1'b0));
  endtask

  task automatic reset_cycles(input int n);
    last_len  = 8'h00;
    last_byte = 8'h00;
    for (int i = 0; i < n; i++) step(i[0], 1'b0, mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0));
  endtask

  // Payload bit k (1..len) is p[len-k]; only the first nsend payload bits are driven.
  task automatic send_frame(input logic [7:0] len, input logic [254:0] p, input int nsend);
    logic [7:0] acc;
    int         nb;
    logic       b, bv;
    step(1'b0, 1'b1, mk(1'b1, 1'b0, last_len, 1'b0, 1'b1, 1'b0, last_byte, 1'b0));
    for (int i = 7; i >= 1; i--)
      step(len[i], 1'b1, mk(1'b1, 1'b0, last_len, 1'b0, 1'b1, 1'b0, last_byte, 1'b0));
    last_len = len;
    step(len[0], 1'b1, mk(1'b1, 1'b0, len, 1'b1, len != 8'd0, len == 8'd0, last_byte, 1'b0));
    acc = 8'h00;
    nb  = 0;
    for (int k = 1; k <= nsend; k++) begin
      b   = p[int'(len) - k];
      acc = {acc[6:0], b};
      nb++;
      bv  = 1'b0;
      if (nb == 8 || k == int'(len)) begin
        bv        = 1'b1;
        last_byte = acc << (8 - nb);
        acc       = 8'h00;
        nb        = 0;
      end
      step(b, 1'b1, mk(b, 1'b1, last_len, 1'b0, k < int'(len), k == int'(len), last_byte, bv));
    end
  endtask

  logic [254:0] big;

  initial begin
    bus.serial_in = 1'b1;
    rst = 1'b0;

    tag = "reset";
    reset_cycles(3);
    idle(2);

    tag = "basic_a5";
    dv_cnt = 0; bv_cnt = 0;
    send_frame(8'h08, 255'hA5, 8);
    idle(2);
    check_val("basic_dv_count", dv_cnt, 8);
    check_val("basic_bv_count", bv_cnt, 1);

    tag = "zero_len";
    dv_cnt = 0;
    send_frame(8'h00, 255'h0, 0);
    idle(2);
    check_val("zero_dv_count", dv_cnt, 0);

    tag = "partial_3";
    send_frame(8'h03, 255'b110, 3);
    idle(2);

    tag = "back_to_back";
    send_frame(8'h02, 255'b10, 2);
    send_frame(8'h01, 255'b1, 1);
    idle(2);

    tag = "mid_reset";
    send_frame(8'h10, 255'hBEEF, 4);
    reset_cycles(1);
    tag = "after_reset";
    send_frame(8'h08, 255'h3C, 8);
    idle(2);

    tag = "random";
    for (int f = 0; f < 3; f++) begin
      logic [7:0] l;
      l   = 8'($urandom_range(1, 20));
      big = '0;
      for (int i = 0; i < 20; i++) big[i] = 1'($urandom_range(0, 1));
      send_frame(l, big, int'(l));
      idle(f);
    end
    idle(1);

    tag = "max_len";
    for (int i = 0; i < 255; i++) big[i] = 1'($urandom_range(0, 1));
    dv_cnt = 0; bv_cnt = 0;
    send_frame(8'hFF, big, 255);
    idle(2);
    check_val("max_dv_count", dv_cnt, 255);
    check_val("max_bv_count", bv_cnt, 32);

    check_val("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
